raster_fifo_writer: RTL and testbench
=====================================

# raster_fifo_writer

Upstream stage of the raster sample FIFO (`ram_fifo`). Takes per-point samples from the raster/ADC front end, frames them into lines, optionally prefixes each line with a header word, and drives the FIFO write port (`write_enable`, `write_dat`). When the FIFO is full it drops samples rather than stalling the scan, and reports the loss through sticky status so host software can flag corrupted images.

## Interface
- `DAT_WID`, 24: sample and FIFO word width; must be ≥ 16.
- `LINE_LEN`, 256: samples per raster line; ≥ 1.
- `LINES`, 256: lines per frame; ≥ 1.
- `CNT_WID`, 16: width of the line index and drop counter.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `scan_arm` in 1: single-cycle pulse; starts a frame from IDLE or DONE.
- `abort` in 1: returns to IDLE on the next edge; has priority over all other inputs.
- `line_start` in 1: marks the start of a line; arrives ≥ 2 cycles before that line's first `sample_valid`.
- `sample_valid` in 1: `sample_dat` is valid this cycle.
- `sample_dat` in DAT_WID: sample value.
- `fifo_full` in 1: FIFO cannot accept a write this cycle.
- `write_enable` out 1: FIFO write strobe; registered.
- `write_dat` out DAT_WID: FIFO write data; registered.
- `busy` out 1: high in any state except IDLE and DONE.
- `done` out 1: high in DONE.
- `overflow` out 1: sticky; at least one sample dropped this frame.
- `drop_cnt` out CNT_WID: count of dropped samples this frame; saturates at all-ones.
- `line_idx` out CNT_WID: index of the current line.

## Operation
- States: IDLE, ARMED, HEADER, STREAM, DONE.
- IDLE: on `scan_arm` go to ARMED. Also clears `overflow`, `drop_cnt`, `line_idx` and the sample counter.
- ARMED: on `line_start` go to HEADER if headers are compiled in, otherwise STREAM. `sample_valid` in ARMED is ignored and is not counted as a drop.
- HEADER: lasts one cycle. Issues one write of the header word, then goes to STREAM. If `fifo_full` is high in that cycle, the header is not written and `overflow` is set. The drop counter does not increment for a lost header.
- STREAM, on `sample_valid`:
  - If `fifo_full` is low, write `sample_dat`.
  - If `fifo_full` is high, drop the sample, set `overflow` and increment `drop_cnt`.
  - In both cases the sample counter increments.
- End of line: when the sample counter reaches LINE_LEN, reset it to 0 and increment `line_idx`. If the new `line_idx` equals LINES, go to DONE; otherwise go to ARMED.
- DONE: holds all status values. `scan_arm` re-arms: clear everything as in IDLE and go to ARMED.
- `line_start` outside ARMED is ignored.
- `abort`, or reset in the middle of a frame, drops any pending write. `write_enable` is 0 on the following cycle. Status is kept until the next arm.

## Timing
- Reset values: `write_enable`=0, `write_dat`=0, `busy`=0, `done`=0, `overflow`=0, `drop_cnt`=0, `line_idx`=0, state=IDLE.
- Write latency: `write_enable`/`write_dat` are asserted exactly 1 cycle after the accepting `sample_valid` or the HEADER cycle.
- `fifo_full` is sampled in the same cycle as `sample_valid`.
- `write_enable` is high for one cycle per accepted word. Back-to-back samples give back-to-back writes.
- Header word: `{8'hA5, line_idx}` placed in the upper bits, with `line_idx` zero-extended or truncated to DAT_WID−8 bits.
- Status (`overflow`, `drop_cnt`, `line_idx`, `done`) updates 1 cycle after the causing event.
- Throughput: one sample per clock, sustained.

## Configuration
- `RASTER_WRITER_HEADER_EN` defined: the HEADER state exists, and each line emits LINE_LEN+1 words.
- Not defined: ARMED goes directly to STREAM, HEADER logic is removed, and each line emits LINE_LEN words.

## Structure
- Shared package `raster_pkg`:
  - state enum.
  - header magic `8'hA5`.
  - header field widths.
- Natural sub-module: `sat_counter`, a saturating counter of width CNT_WID with clear and increment, used for `drop_cnt`.
- The line and sample counters stay inline.

## Test plan
- Single line, no full: LINE_LEN=4, LINES=1, headers on, samples 1,2,3,4 → writes A5_0000, 1, 2, 3, 4, each 1 cycle after its cause; then `done`=1 and `drop_cnt`=0.
- Overflow: assert `fifo_full` during the 2nd and 3rd of 4 samples → only samples 1 and 4 are written; `overflow`=1, `drop_cnt`=2, and the line still ends after 4 samples.
- Multi-line: LINES=3 → 3 headers with `line_idx` 0, 1, 2; `busy` drops and `done` rises 1 cycle after the last sample; `sample_valid` between lines (ARMED) produces no writes and no drops.
- Abort mid-line after 2 samples → `write_enable` is 0 the next cycle and state is IDLE; a later `scan_arm` clears `drop_cnt` and `line_idx`.
- Async reset asserted mid-STREAM → all outputs at reset values immediately, with no clock edge required.
- Macro undefined, LINE_LEN=4 → exactly 4 writes per line and no A5 word.

Source files
------------

// File: rtl/raster_pkg.sv
// raster_pkg: types and constants shared by the raster FIFO writer.
//   state_e     - writer FSM states
//   HDR_MAGIC_W - width of the magic field at the top of a header word
//   HDR_MAGIC   - magic byte that marks a line header in the FIFO stream
package raster_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HEADER,
    ST_STREAM,
    ST_DONE
  } state_e;

  localparam int                     HDR_MAGIC_W = 8;
  localparam logic [HDR_MAGIC_W-1:0] HDR_MAGIC   = 8'hA5;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n - clock, async active-low reset
//   clr        - synchronous clear (wins over inc)
//   inc        - count up by one
//   cnt        - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/raster_fifo_writer.sv
// raster_fifo_writer: frames raster samples into lines and drives the FIFO
// write port. Samples arriving while the FIFO is full are dropped (the scan
// never stalls) and the loss is reported via sticky overflow / drop_cnt.
//
// Build option: RASTER_WRITER_HEADER_EN - when defined, each line is prefixed
// by one header word {HDR_MAGIC, line_idx}.
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   scan_arm              - pulse: start a frame from IDLE or DONE
//   abort                 - back to IDLE next edge, highest priority
//   line_start            - start of line (honoured only in ARMED)
//   sample_valid/_dat     - incoming sample
//   fifo_full             - FIFO cannot accept a write this cycle
//   write_enable/_dat     - registered FIFO write port
//   busy, done            - frame in progress / frame complete
//   overflow, drop_cnt    - sticky loss flag, saturating drop count
//   line_idx              - index of the current line
module raster_fifo_writer
  import raster_pkg::*;
#(
  parameter int DAT_WID  = 24,
  parameter int LINE_LEN = 256,
  parameter int LINES    = 256,
  parameter int CNT_WID  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_arm,
  input  logic               abort,
  input  logic               line_start,
  input  logic               sample_valid,
  input  logic [DAT_WID-1:0] sample_dat,
  input  logic               fifo_full,
  output logic               write_enable,
  output logic [DAT_WID-1:0] write_dat,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [CNT_WID-1:0] drop_cnt,
  output logic [CNT_WID-1:0] line_idx
);

  localparam int                SCNT_W    = $clog2(LINE_LEN + 1);
  localparam logic [SCNT_W-1:0] SMP_LAST  = SCNT_W'(LINE_LEN - 1);
  localparam logic [CNT_WID:0]  LINE_LAST = (CNT_WID + 1)'(LINES - 1);

  state_e              state, nxt;
  logic [SCNT_W-1:0]   smp_cnt;
  logic                arm_clr, smp_adv, drop, ovf_set, wr_d;
  logic [DAT_WID-1:0]  wr_dat_d;
  logic                line_end, last_line;

`ifdef RASTER_WRITER_HEADER_EN
  localparam int HDR_IDX_W = DAT_WID - HDR_MAGIC_W;
  logic [HDR_IDX_W-1:0] hdr_idx;
  assign hdr_idx = HDR_IDX_W'(line_idx);
`endif

  // Decided on the accepting sample itself so the line closes on that edge.
  assign line_end  = (smp_cnt == SMP_LAST);
  assign last_line = ({1'b0, line_idx} == LINE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    arm_clr  = 1'b0;
    smp_adv  = 1'b0;
    drop     = 1'b0;
    ovf_set  = 1'b0;
    wr_d     = 1'b0;
    wr_dat_d = write_dat;
    if (abort) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (scan_arm) begin
            arm_clr = 1'b1;
            nxt     = ST_ARMED;
          end
        end
        ST_ARMED: begin
`ifdef RASTER_WRITER_HEADER_EN
          if (line_start) nxt = ST_HEADER;
`else
          if (line_start) nxt = ST_STREAM;
`endif
        end
`ifdef RASTER_WRITER_HEADER_EN
        ST_HEADER: begin
          // A lost header flags overflow but is not a dropped sample.
          wr_d     = !fifo_full;
          wr_dat_d = {HDR_MAGIC, hdr_idx};
          ovf_set  = fifo_full;
          nxt      = ST_STREAM;
        end
`endif
        ST_STREAM: begin
          if (sample_valid) begin
            smp_adv = 1'b1;
            if (fifo_full) begin
              drop    = 1'b1;
              ovf_set = 1'b1;
            end else begin
              wr_d     = 1'b1;
              wr_dat_d = sample_dat;
            end
            if (line_end) nxt = last_line ? ST_DONE : ST_ARMED;
          end
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable <= 1'b0;
      write_dat    <= '0;
      smp_cnt      <= '0;
      line_idx     <= '0;
      overflow     <= 1'b0;
    end else begin
      write_enable <= wr_d;
      write_dat    <= wr_dat_d;
      if (arm_clr) begin
        smp_cnt  <= '0;
        line_idx <= '0;
        overflow <= 1'b0;
      end else begin
        if (smp_adv) smp_cnt <= line_end ? '0 : smp_cnt + 1'b1;
        if (smp_adv && line_end) line_idx <= line_idx + 1'b1;
        if (ovf_set) overflow <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_WID)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (arm_clr),
    .inc   (drop),
    .cnt   (drop_cnt)
  );

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_raster_fifo_writer.sv
module tb_raster_fifo_writer;

  localparam int DAT_WID  = 24;
  localparam int LINE_LEN = 4;
  localparam int LINES    = 3;
  localparam int CNT_WID  = 16;
`ifdef RASTER_WRITER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               scan_arm, abort, line_start, sample_valid, fifo_full;
  logic [DAT_WID-1:0] sample_dat;
  logic               write_enable, busy, done, overflow;
  logic [DAT_WID-1:0] write_dat;
  logic [CNT_WID-1:0] drop_cnt, line_idx;

  always #5 clk = ~clk;

  raster_fifo_writer #(
    .DAT_WID(DAT_WID), .LINE_LEN(LINE_LEN), .LINES(LINES), .CNT_WID(CNT_WID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_arm(scan_arm), .abort(abort),
    .line_start(line_start), .sample_valid(sample_valid),
    .sample_dat(sample_dat), .fifo_full(fifo_full),
    .write_enable(write_enable), .write_dat(write_dat), .busy(busy),
    .done(done), .overflow(overflow), .drop_cnt(drop_cnt), .line_idx(line_idx)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: frame progress expressed as phase + counters.
  localparam int P_IDLE = 0, P_WAIT = 1, P_HDR = 2, P_STRM = 3, P_DONE = 4;
  int               m_phase, m_smp, m_line, m_drops;
  bit               m_ovf, m_rst, exp_we;
  logic [23:0]      exp_wd;

  task automatic model_reset();
    m_phase = P_IDLE; m_smp = 0; m_line = 0; m_drops = 0; m_ovf = 0;
    m_rst = 1; exp_we = 0; exp_wd = '0;
  endtask

  task automatic model_step();
    logic [15:0] l16;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_rst  = 0;
    exp_we = 0;
    if (abort) begin
      m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE, P_DONE:
        if (scan_arm) begin
          m_phase = P_WAIT; m_smp = 0; m_line = 0; m_drops = 0; m_ovf = 0;
        end
      P_WAIT: if (line_start) m_phase = HDR_EN ? P_HDR : P_STRM;
      P_HDR: begin
        if (fifo_full) m_ovf = 1;
        else begin
          l16 = m_line[15:0];
          exp_we = 1; exp_wd = {8'hA5, l16};
        end
        m_phase = P_STRM;
      end
      P_STRM:
        if (sample_valid) begin
          if (fifo_full) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
          end else begin
            exp_we = 1; exp_wd = sample_dat;
          end
          m_smp++;
          if (m_smp == LINE_LEN) begin
            m_smp = 0;
            m_line++;
            m_phase = (m_line == LINES) ? P_DONE : P_WAIT;
          end
        end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("write_enable", {31'd0, write_enable}, {31'd0, exp_we});
    if (exp_we || m_rst) chk("write_dat", {8'd0, write_dat}, {8'd0, exp_wd});
    chk("busy", {31'd0, busy}, {31'd0, (m_phase == P_WAIT || m_phase == P_HDR || m_phase == P_STRM)});
    chk("done", {31'd0, done}, {31'd0, (m_phase == P_DONE)});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("drop_cnt", {16'd0, drop_cnt}, m_drops);
    chk("line_idx", {16'd0, line_idx}, m_line);
  endtask

  task automatic cyc(input bit arm, input bit ab, input bit ls, input bit sv,
                     input logic [23:0] sd, input bit full);
    @(negedge clk);
    check_outputs();
    scan_arm = arm; abort = ab; line_start = ls; sample_valid = sv;
    sample_dat = sd; fifo_full = full;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 24'($urandom), $urandom_range(0, 1));
  endtask

  // One frame; pfull is the percentage chance of fifo_full per write slot.
  task automatic run_frame(input int pfull);
    cyc(1, 0, 0, 0, '0, 0);
    for (int l = 0; l < LINES; l++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--)
        cyc(0, 0, 0, $urandom_range(0, 1), 24'($urandom), $urandom_range(0, 1));
      cyc(0, 0, 1, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, ($urandom_range(0, 99) < pfull));
      for (int s = 0; s < LINE_LEN; s++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          cyc(0, 0, $urandom_range(0, 1), 0, 24'($urandom), 0);
        cyc(0, 0, 0, 1, 24'($urandom), ($urandom_range(0, 99) < pfull));
      end
    end
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0; scan_arm = 0; abort = 0; line_start = 0;
    sample_valid = 0; sample_dat = '0; fifo_full = 0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Directed: samples 1..4 on line 0, full on samples 2 and 3.
    cyc(1, 0, 0, 0, '0, 0);
    cyc(0, 0, 1, 0, '0, 0);
    cyc(0, 0, 0, 0, '0, 0);
    cyc(0, 0, 0, 1, 24'd1, 0);
    cyc(0, 0, 0, 1, 24'd2, 1);
    cyc(0, 0, 0, 1, 24'd3, 1);
    cyc(0, 0, 0, 1, 24'd4, 0);
    for (int l = 1; l < LINES; l++) begin
      cyc(0, 0, 0, 1, 24'hBAD, 1);   // ignored in ARMED
      cyc(0, 0, 1, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 0);
      for (int s = 0; s < LINE_LEN; s++) cyc(0, 0, 0, 1, 24'(16 * l + s), 0);
    end
    idle(2);

    for (int f = 0; f < 25; f++) run_frame((f % 4) * 25);

    // Abort after two samples (one dropped), with a sample in the abort cycle.
    cyc(1, 0, 0, 0, '0, 0);
    cyc(0, 0, 1, 0, '0, 0);
    cyc(0, 0, 0, 0, '0, 0);
    cyc(0, 0, 0, 1, 24'h111, 1);
    cyc(0, 0, 0, 1, 24'h222, 0);
    cyc(0, 1, 0, 1, 24'h333, 0);
    idle(2);
    cyc(1, 0, 0, 0, '0, 0);
    idle(1);

    // Async reset in the middle of a line.
    cyc(0, 0, 1, 0, '0, 0);
    cyc(0, 0, 0, 0, '0, 0);
    cyc(0, 0, 0, 1, 24'h555, 1);
    cyc(0, 0, 0, 1, 24'h666, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    idle(1);
    rst_n = 1'b1;
    idle(1);
    run_frame(30);

    @(negedge clk);
    check_outputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
